tutankham_rom_router: RTL

TUTANKHAM_ROM_ROUTER -- requirements
Module: tutankham_rom_router

---
 rtl/tutankham_rom_router.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tutankham_rom_router.sv
// Tutankham ROM download router: decodes the ioctl download stream into
// per-region write strobes and tracks per-region fill progress and checksums.

package tutankham_rom_router_pkg;
    // Region i based at i*0x2000, packed ADDR_W bits per region.
    function automatic logic [2047:0] default_base(input int n, input int w);
        logic [2047:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            r = r | (2048'(i * 32'h2000) << (i * w));
        return r;
    endfunction
endpackage

module tutankham_rom_router #(
    parameter int NUM_REGIONS = 15,
    parameter int ADDR_W      = 25,
    parameter int OFS_W       = 14,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        (NUM_REGIONS*ADDR_W)'(tutankham_rom_router_pkg::default_base(NUM_REGIONS, ADDR_W)),
    parameter logic [NUM_REGIONS*5-1:0] REGION_LOG2 = {NUM_REGIONS{5'd13}}
) (
    input  logic                   clk_49m,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    input  logic [7:0]             ioctl_data,
    input  logic                   ioctl_wr,
    input  logic [((NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1)-1:0] sum_sel,
    output logic [NUM_REGIONS-1:0] rom_cs,
    output logic [OFS_W-1:0]       rom_addr,
    output logic [7:0]             rom_data,
    output logic [NUM_REGIONS-1:0] region_loaded,
    output logic [7:0]             region_sum,
    output logic                   load_done,
    output logic                   addr_err
);
    localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                 state;
    logic                   wr_prev, dl_prev;
    // Download must be seen low once after reset before a rise counts, so a
    // download held high through reset is not mistaken for a new one.
    logic                   dl_armed;
    logic                   dl_rise, dl_fall, accept;
    logic                   hit;
    logic [NUM_REGIONS-1:0] hit_cs;
    logic [OFS_W-1:0]       ofs;
    logic [7:0]             sums [NUM_REGIONS];

    assign dl_rise = ioctl_download & ~dl_prev & dl_armed;
    assign dl_fall = ~ioctl_download & dl_prev;
    // Writes count only on a wr rising edge inside a download, including the
    // cycle that opens it.
    assign accept  = ioctl_wr & ~wr_prev & ioctl_download & ((state == LOAD) | dl_rise);
    assign hit     = |hit_cs;

    // Address decode: scan high to low so the lowest matching region wins
    always_comb begin : decode
        logic [ADDR_W:0] lo, sz, a;
        hit_cs = '0;
        ofs    = '0;
        lo     = '0;
        sz     = '0;
        a      = {1'b0, ioctl_addr};
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            lo = {1'b0, REGION_BASE[i*ADDR_W +: ADDR_W]};
            sz = (ADDR_W+1)'(1) << REGION_LOG2[i*5 +: 5];
            if (a >= lo && a < lo + sz) begin
                hit_cs    = '0;
                hit_cs[i] = 1'b1;
                ofs       = OFS_W'(a - lo);
            end
        end
    end

    // Control FSM, edge history and registered strobe outputs
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state     <= IDLE;
            wr_prev   <= 1'b0;
            dl_prev   <= 1'b0;
            dl_armed  <= 1'b0;
            rom_cs    <= '0;
            rom_addr  <= '0;
            rom_data  <= '0;
            addr_err  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            wr_prev <= ioctl_wr;
            dl_prev <= ioctl_download;
            if (!ioctl_download)
                dl_armed <= 1'b1;
            rom_cs <= '0;
            if (dl_rise)
                addr_err <= 1'b0;
            if (accept) begin
                if (hit) begin
                    rom_cs   <= hit_cs;
                    rom_addr <= ofs;
                    rom_data <= ioctl_data;
                end else begin
                    addr_err <= 1'b1;
                end
            end
            case (state)
                IDLE, DONE: if (dl_rise) begin
                    state     <= LOAD;
                    load_done <= 1'b0;
                end
                LOAD: if (dl_fall) begin
                    state     <= DONE;
                    load_done <= &region_loaded;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam logic [OFS_W:0] FULL = (OFS_W+1)'(1) << REGION_LOG2[g*5 +: 5];

        logic [OFS_W:0] cnt, cnt_base;
        logic [7:0]     sum, sum_base;
        logic           loaded, loaded_base;

        // Entering LOAD wipes progress before this cycle's write is applied
        always_comb begin
            cnt_base    = dl_rise ? '0   : cnt;
            sum_base    = dl_rise ? 8'h0 : sum;
            loaded_base = dl_rise ? 1'b0 : loaded;
        end

        // Saturating byte counter, fill flag and running checksum
        always_ff @(posedge clk_49m) begin
            if (reset) begin
                cnt    <= '0;
                sum    <= '0;
                loaded <= 1'b0;
            end else begin
                cnt    <= cnt_base;
                sum    <= sum_base;
                loaded <= loaded_base;
                if (accept && hit_cs[g]) begin
                    sum <= sum_base + ioctl_data;
                    if (cnt_base != FULL) begin
                        cnt <= cnt_base + 1'b1;
                        if (cnt_base + 1'b1 == FULL)
                            loaded <= 1'b1;
                    end
                end
            end
        end

        assign region_loaded[g] = loaded;
        assign sums[g]          = sum;
    end

    // Checksum readout; out-of-range selects read zero
    always_comb begin
        region_sum = 8'h00;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (sum_sel == SEL_W'(i))
                region_sum = sums[i];
    end

endmodule
